tns_dec_seq_ctrl: RTL and testbench

TNS_DEC_SEQ_CTRL -- requirements
Module: tns_dec_seq_ctrl

---
 rtl/tns_dec_seq_ctrl_pkg.sv | 34 +++
 rtl/TNS.vh | 37 +++
 rtl/tns_wsel.sv | 34 +++
 rtl/tns_dec_seq_ctrl.sv | 115 +++++++++++
 tb/tb_tns_dec_seq_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/tns_dec_seq_ctrl_pkg.sv
// Shared types and constants for the sequential TNS decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`include "TNS.vh"

package tns_dec_seq_ctrl_pkg;

    localparam int CODE_W = 27;
    localparam int DATA_W = `BLEN09;
    localparam int NGRP   = `TNS_NGRP;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NGRP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Extract the three bits {A,B,C} of group idx; out-of-range idx yields 0.
    function automatic logic [2:0] grp_of(input logic [CODE_W-1:0] code,
                                          input logic [CNT_W-1:0]  idx);
        logic [2:0] r;
        r = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (idx == CNT_W'(g)) begin
                r = code[3*g +: 3];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/TNS.vh
`ifndef TNS_VH
`define TNS_VH

// Decoded value width: nine groups whose largest legal value fits in 15 bits.
`define BLEN09   15
`define TNS_NGRP 9

// Group weights: C = 3^g, B = 2*3^g, A = 3*3^g for group index g = 0..8.
`define TNS01_A 15'd3
`define TNS01_B 15'd2
`define TNS01_C 15'd1
`define TNS02_A 15'd9
`define TNS02_B 15'd6
`define TNS02_C 15'd3
`define TNS03_A 15'd27
`define TNS03_B 15'd18
`define TNS03_C 15'd9
`define TNS04_A 15'd81
`define TNS04_B 15'd54
`define TNS04_C 15'd27
`define TNS05_A 15'd243
`define TNS05_B 15'd162
`define TNS05_C 15'd81
`define TNS06_A 15'd729
`define TNS06_B 15'd486
`define TNS06_C 15'd243
`define TNS07_A 15'd2187
`define TNS07_B 15'd1458
`define TNS07_C 15'd729
`define TNS08_A 15'd6561
`define TNS08_B 15'd4374
`define TNS08_C 15'd2187
`define TNS09_A 15'd19683
`define TNS09_B 15'd13122
`define TNS09_C 15'd6561

`endif

// File: rtl/tns_wsel.sv
// Weight selector: maps a group index to its A/B/C weights from TNS.vh.
// Latency: combinational.
// Backpressure: none.
`include "TNS.vh"

module tns_wsel
    import tns_dec_seq_ctrl_pkg::*;
(
    input  logic [3:0]        grp_i,
    output logic [DATA_W-1:0] wa_o,
    output logic [DATA_W-1:0] wb_o,
    output logic [DATA_W-1:0] wc_o
);

    // Table lookup; indices past the last group return zero weights.
    always_comb begin
        wa_o = '0;
        wb_o = '0;
        wc_o = '0;
        case (grp_i)
            4'd0: begin wa_o = `TNS01_A; wb_o = `TNS01_B; wc_o = `TNS01_C; end
            4'd1: begin wa_o = `TNS02_A; wb_o = `TNS02_B; wc_o = `TNS02_C; end
            4'd2: begin wa_o = `TNS03_A; wb_o = `TNS03_B; wc_o = `TNS03_C; end
            4'd3: begin wa_o = `TNS04_A; wb_o = `TNS04_B; wc_o = `TNS04_C; end
            4'd4: begin wa_o = `TNS05_A; wb_o = `TNS05_B; wc_o = `TNS05_C; end
            4'd5: begin wa_o = `TNS06_A; wb_o = `TNS06_B; wc_o = `TNS06_C; end
            4'd6: begin wa_o = `TNS07_A; wb_o = `TNS07_B; wc_o = `TNS07_C; end
            4'd7: begin wa_o = `TNS08_A; wb_o = `TNS08_B; wc_o = `TNS08_C; end
            4'd8: begin wa_o = `TNS09_A; wb_o = `TNS09_B; wc_o = `TNS09_C; end
            default: begin wa_o = '0; wb_o = '0; wc_o = '0; end
        endcase
    end

endmodule

// File: rtl/tns_dec_seq_ctrl.sv
// Sequential TNS decoder: accumulates one 3-bit group of weights per cycle.
// Latency: out_valid rises 9 edges after the accepting edge, for every code.
// Backpressure: result held in DONE until out_ready; in_ready low until then.
module tns_dec_seq_ctrl
    import tns_dec_seq_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] codein,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dataout,
    output logic              busy
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               rdy_en_q;
    logic [2:0]         grp_bits;
    logic [DATA_W-1:0]  w_a, w_b, w_c;

    tns_wsel u_wsel (
        .grp_i (cnt_q),
        .wa_o  (w_a),
        .wb_o  (w_b),
        .wc_o  (w_c)
    );

    // Current group's A/B/C bits selected by the group counter.
    always_comb begin
        grp_bits = grp_of(code_q, cnt_q);
    end

    // Next-state, counter, accumulator and code capture; clr overrides all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        code_d  = code_q;
        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        code_d  = codein;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Sum wraps modulo 2^DATA_W; invalid codes decode silently.
                    acc_d = acc_q
                          + ({DATA_W{grp_bits[2]}} & w_a)
                          + ({DATA_W{grp_bits[1]}} & w_b)
                          + ({DATA_W{grp_bits[0]}} & w_c);
                    if (cnt_q == LAST_GRP) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            code_q  <= code_d;
        end
    end

    // Keeps in_ready low during reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !clr && rdy_en_q;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign dataout   = acc_q;

endmodule

// File: tb/tb_tns_dec_seq_ctrl.sv
`include "TNS.vh"

module tb_tns_dec_seq_ctrl;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                clr = 1'b0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic [26:0]         codein = '0;
    logic                in_ready;
    logic                out_valid;
    logic                busy;
    logic [`BLEN09-1:0]  dataout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit accepted;

    logic [`BLEN09-1:0] exp_q[$];
    int                 acc_cyc_q[$];

    // Weight of every code bit, bit 3g = C, 3g+1 = B, 3g+2 = A of group g+1.
    int wt[27] = '{`TNS01_C, `TNS01_B, `TNS01_A, `TNS02_C, `TNS02_B, `TNS02_A,
                   `TNS03_C, `TNS03_B, `TNS03_A, `TNS04_C, `TNS04_B, `TNS04_A,
                   `TNS05_C, `TNS05_B, `TNS05_A, `TNS06_C, `TNS06_B, `TNS06_A,
                   `TNS07_C, `TNS07_B, `TNS07_A, `TNS08_C, `TNS08_B, `TNS08_A,
                   `TNS09_C, `TNS09_B, `TNS09_A};

    tns_dec_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .codein    (codein),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Golden decode: sum of the weights of all set bits, modulo 2^BLEN09.
    function automatic logic [`BLEN09-1:0] golden(input logic [26:0] c);
        int s;
        s = 0;
        for (int i = 0; i < 27; i++) begin
            if (c[i]) s += wt[i];
        end
        return `BLEN09'(s % (1 << `BLEN09));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; records an expected result whenever a transfer will occur.
    task automatic drive_cycle(input bit v, input logic [26:0] c, input bit ordy, input bit cl);
        @(posedge clk);
        #1;
        in_valid  = v;
        codein    = c;
        out_ready = ordy;
        clr       = cl;
        #1;
        accepted = 1'b0;
        if (in_valid && in_ready) begin
            exp_q.push_back(golden(c));
            acc_cyc_q.push_back(cyc + 1);
            accepted = 1'b1;
        end
    endtask

    task automatic send_word(input logic [26:0] c, input bit ordy);
        for (int k = 0; k < 50; k++) begin
            drive_cycle(1'b1, c, ordy, 1'b0);
            if (accepted) break;
        end
        chk("accept_timeout", accepted, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0) break;
            drive_cycle(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: latency at out_valid rise, hold stability, and result on handshake.
    logic               prev_vld = 1'b0;
    logic [`BLEN09-1:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_cyc_q.delete();
            prev_vld = 1'b0;
        end else begin
            if (out_valid && !prev_vld) begin
                if (!clr) begin
                    if (acc_cyc_q.size() == 0) chk("out_valid_unexpected", out_valid, 0);
                    else chk("latency", cyc - acc_cyc_q.pop_front(), 9);
                end
                held = dataout;
            end else if (out_valid) begin
                chk("dataout_hold", dataout, held);
            end
            if (out_valid) chk("in_ready_in_done", in_ready, 0);
            if (clr) begin
                exp_q.delete();
                acc_cyc_q.delete();
            end else if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("handshake_unexpected", out_valid, 0);
                else chk("dataout", dataout, exp_q.pop_front());
            end
            prev_vld = out_valid;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [26:0] c;
        int n_words;

        // Reset state
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dataout", dataout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #2;
        chk("in_ready_after_edge", in_ready, 1);

        // Zero codeword
        send_word(27'h0000000, 1'b1);
        drain();

        // One-hot sweep over all 27 bit positions
        for (int i = 0; i < 27; i++) begin
            c = 27'h1 << i;
            send_word(c, 1'b1);
            drain();
        end

        // Backpressure: hold DONE for 20 cycles, try to inject a word meanwhile
        send_word(27'h5A5A5A5, 1'b0);
        for (int k = 0; k < 15; k++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b0);
            if (out_valid) break;
        end
        chk("bp_out_valid", out_valid, 1);
        for (int k = 0; k < 20; k++) begin
            drive_cycle(1'b1, 27'($urandom), 1'b0, 1'b0);
            chk("bp_still_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);

        // Abort with clr while the counter is at group 4
        send_word(27'h7FFFFFF, 1'b1);
        for (int k = 0; k < 4; k++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("abort_busy_before", busy, 1);
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_dataout", dataout, 0);
        chk("abort_in_ready", in_ready, 1);
        for (int k = 0; k < 12; k++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        send_word(27'h1234567, 1'b1);
        drain();

        // Asynchronous reset mid-run
        send_word(27'h7FFFFFF, 1'b1);
        for (int k = 0; k < 3; k++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_dataout", dataout, 0);
        @(posedge clk);
        #2;
        chk("arst_in_ready_hold", in_ready, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        chk("arst_release_ready", in_ready, 1);
        for (int k = 0; k < 14; k++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
        send_word(27'h0ABCDEF, 1'b1);
        drain();

        // Randomised traffic with random valid/ready and rare clr
        n_words = 0;
        for (int k = 0; k < 55000; k++) begin
            drive_cycle($urandom_range(0, 7) != 0, 27'($urandom),
                        $urandom_range(0, 7) != 0, $urandom_range(0, 999) == 0);
            if (accepted) n_words++;
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drain();
        chk("random_words_seen", (n_words > 1000) ? 1 : 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
